// File: rtl/clk_div_monitor.sv
// Shape monitor for a divided clock: measures period and high time of clk_div at
// half-cycle resolution of clk_in, tracks lock and keeps sticky error flags.
module clk_div_monitor #(
  parameter int PERIOD_HALF   = 9,
  parameter int HIGH_MIN_HALF = 4,
  parameter int HIGH_MAX_HALF = 5,
  parameter int LOCK_COUNT    = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             en,
  input  logic             clr_err,
  output logic             locked,
  output logic             period_err,
  output logic             high_err,
  output logic             timeout_err,
  output logic             meas_valid,
  output logic [CNT_W-1:0] last_period,
  output logic [CNT_W-1:0] last_high
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    CHECK,
    LOCKED
  } state_t;

  localparam int                GOOD_W      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  PERIOD_VAL  = CNT_W'(PERIOD_HALF);
  localparam logic [CNT_W-1:0]  HIGH_MIN    = CNT_W'(HIGH_MIN_HALF);
  localparam logic [CNT_W-1:0]  HIGH_MAX    = CNT_W'(HIGH_MAX_HALF);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(2 * PERIOD_HALF);
  localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [GOOD_W-1:0] LOCK_FULL   = GOOD_W'(LOCK_COUNT);

  state_t             state_reg, state_next;
  logic               s_n_reg;
  logic               pair_a_reg, pair_b_reg, prev_reg;
  logic [CNT_W-1:0]   per_cnt_reg, per_cnt_next;
  logic [CNT_W-1:0]   high_cnt_reg, high_cnt_next;
  logic [GOOD_W-1:0]  good_cnt_reg, good_cnt_next;
  logic               locked_reg, locked_next;
  logic               period_err_reg, period_err_next;
  logic               high_err_reg, high_err_next;
  logic               timeout_err_reg, timeout_err_next;
  logic               meas_valid_reg, meas_valid_next;
  logic [CNT_W-1:0]   last_period_reg, last_period_next;
  logic [CNT_W-1:0]   last_high_reg, last_high_next;

  logic               rise_a, rise_b, rise;
  logic [CNT_W-1:0]   acc_per, acc_high, meas_period, meas_high, rst_per, rst_high;
  logic               timeout, period_ok, high_ok;
  logic               new_period_err, new_high_err, new_timeout_err;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Falling-edge half of the sample pair.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s_n_reg <= 1'b0;
    end else begin
      s_n_reg <= clk_div;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pair_a_reg <= 1'b0;
      pair_b_reg <= 1'b0;
      prev_reg   <= 1'b0;
    end else begin
      pair_a_reg <= s_n_reg;
      pair_b_reg <= clk_div;
      prev_reg   <= pair_b_reg;
    end
  end

  // Pair is evaluated a then b; a rising edge on a excludes one on b.
  always_comb begin
    rise_a   = ~prev_reg & pair_a_reg;
    rise_b   = ~pair_a_reg & pair_b_reg;
    rise     = rise_a | rise_b;
    acc_per  = sat_add(per_cnt_reg, 2'd2);
    acc_high = sat_add(high_cnt_reg, 2'(pair_a_reg) + 2'(pair_b_reg));
    if (rise_a) begin
      meas_period = per_cnt_reg;
      meas_high   = high_cnt_reg;
      rst_per     = CNT_W'(2);
      rst_high    = pair_b_reg ? CNT_W'(2) : CNT_W'(1);
    end else begin
      meas_period = sat_add(per_cnt_reg, 2'd1);
      meas_high   = sat_add(high_cnt_reg, 2'(pair_a_reg));
      rst_per     = CNT_W'(1);
      rst_high    = CNT_W'(1);
    end
    timeout   = ~rise & (acc_per >= TIMEOUT_VAL);
    period_ok = (meas_period == PERIOD_VAL);
    high_ok   = (meas_high >= HIGH_MIN) && (meas_high <= HIGH_MAX);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    per_cnt_next     = per_cnt_reg;
    high_cnt_next    = high_cnt_reg;
    good_cnt_next    = good_cnt_reg;
    locked_next      = locked_reg;
    meas_valid_next  = 1'b0;
    last_period_next = last_period_reg;
    last_high_next   = last_high_reg;
    new_period_err   = 1'b0;
    new_high_err     = 1'b0;
    new_timeout_err  = 1'b0;

    if (!en) begin
      state_next    = IDLE;
      per_cnt_next  = '0;
      high_cnt_next = '0;
      good_cnt_next = '0;
      locked_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = ACQUIRE;
        end
        ACQUIRE: begin
          if (rise) begin
            state_next    = CHECK;
            per_cnt_next  = rst_per;
            high_cnt_next = rst_high;
          end else if (timeout) begin
            new_timeout_err = 1'b1;
            per_cnt_next    = '0;
            high_cnt_next   = '0;
          end else begin
            per_cnt_next  = acc_per;
            high_cnt_next = acc_high;
          end
        end
        CHECK, LOCKED: begin
          if (rise) begin
            per_cnt_next     = rst_per;
            high_cnt_next    = rst_high;
            meas_valid_next  = 1'b1;
            last_period_next = meas_period;
            last_high_next   = meas_high;
            if (period_ok && high_ok) begin
              if (state_reg == CHECK) begin
                if (good_cnt_reg == LOCK_LAST) begin
                  state_next    = LOCKED;
                  locked_next   = 1'b1;
                  good_cnt_next = LOCK_FULL;
                end else begin
                  good_cnt_next = good_cnt_reg + GOOD_W'(1);
                end
              end
            end else begin
              new_period_err = ~period_ok;
              new_high_err   = ~high_ok;
              good_cnt_next  = '0;
              locked_next    = 1'b0;
              state_next     = CHECK;
            end
          end else if (timeout) begin
            new_timeout_err = 1'b1;
            locked_next     = 1'b0;
            good_cnt_next   = '0;
            per_cnt_next    = '0;
            high_cnt_next   = '0;
            state_next      = ACQUIRE;
          end else begin
            per_cnt_next  = acc_per;
            high_cnt_next = acc_high;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    period_err_next  = (period_err_reg & ~clr_err) | new_period_err;
    high_err_next    = (high_err_reg & ~clr_err) | new_high_err;
    timeout_err_next = (timeout_err_reg & ~clr_err) | new_timeout_err;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_reg     <= '0;
      high_cnt_reg    <= '0;
      good_cnt_reg    <= '0;
      locked_reg      <= 1'b0;
      period_err_reg  <= 1'b0;
      high_err_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      meas_valid_reg  <= 1'b0;
      last_period_reg <= '0;
      last_high_reg   <= '0;
    end else begin
      per_cnt_reg     <= per_cnt_next;
      high_cnt_reg    <= high_cnt_next;
      good_cnt_reg    <= good_cnt_next;
      locked_reg      <= locked_next;
      period_err_reg  <= period_err_next;
      high_err_reg    <= high_err_next;
      timeout_err_reg <= timeout_err_next;
      meas_valid_reg  <= meas_valid_next;
      last_period_reg <= last_period_next;
      last_high_reg   <= last_high_next;
    end
  end

  assign locked      = locked_reg;
  assign period_err  = period_err_reg;
  assign high_err    = high_err_reg;
  assign timeout_err = timeout_err_reg;
  assign meas_valid  = meas_valid_reg;
  assign last_period = last_period_reg;
  assign last_high   = last_high_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: directed shape scenarios plus random waveforms, compared every
// cycle against a half-sample history model of the monitor.
module tb_clk_div_monitor;
  localparam int CNT_W    = 8;
  localparam int PER      = 9;
  localparam int HMIN     = 4;
  localparam int HMAX     = 5;
  localparam int LOCK_N   = 4;

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_div = 1'b0;
  logic             en = 1'b0;
  logic             clr_err = 1'b0;
  logic             locked, period_err, high_err, timeout_err, meas_valid;
  logic [CNT_W-1:0] last_period, last_high;

  clk_div_monitor #(
    .PERIOD_HALF(PER), .HIGH_MIN_HALF(HMIN), .HIGH_MAX_HALF(HMAX),
    .LOCK_COUNT(LOCK_N), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_div(clk_div), .en(en), .clr_err(clr_err),
    .locked(locked), .period_err(period_err), .high_err(high_err),
    .timeout_err(timeout_err), .meas_valid(meas_valid),
    .last_period(last_period), .last_high(last_high)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // stimulus state
  bit en_val, clr_hold, clr_pulse;
  bit wq[$];

  // model state: mode 0 idle, 1 acquire, 2 check, 3 locked
  bit hist[$];
  int m_mode, m_good, m_start, m_lp, m_lh;
  bit m_locked, m_perr, m_herr, m_terr, m_mv;

  // observation state
  bit a_now, b_now, pend_a, pend_b, en_s, clr_s, rst_s, locked_d, perr_under_clr;
  int meas_cnt = 0;
  int lock_rise_meas = -1;
  int dut_highs[$];
  int base;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int outvec();
    return int'({locked, period_err, high_err, timeout_err, meas_valid, last_period, last_high});
  endfunction

  function automatic int model_vec();
    logic [CNT_W-1:0] lp, lh;
    lp = CNT_W'(m_lp);
    lh = CNT_W'(m_lh);
    return int'({m_locked, m_perr, m_herr, m_terr, m_mv, lp, lh});
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode = 0; m_good = 0; m_start = 0; m_lp = 0; m_lh = 0;
    m_locked = 0; m_perr = 0; m_herr = 0; m_terr = 0; m_mv = 0;
  endtask

  // Measurements come from the absolute sample index of consecutive rising edges.
  task automatic model_step(input bit a, input bit b, input bit e_in, input bit c_in);
    int  n, edge_i, per, hi;
    bit  prev, np, nh, nt;
    n = hist.size();
    prev = (n > 0) ? hist[n-1] : 1'b0;
    edge_i = -1;
    np = 0; nh = 0; nt = 0;
    hist.push_back(a);
    hist.push_back(b);
    m_mv = 0;
    if (!e_in) begin
      m_mode = 0; m_good = 0; m_locked = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_start = n + 2;
    end else begin
      if (!prev && a) edge_i = n;
      else if (!a && b) edge_i = n + 1;
      if (edge_i >= 0) begin
        if (m_mode != 1) begin
          per = edge_i - m_start;
          hi = 0;
          for (int i = m_start; i < edge_i; i++) hi += int'(hist[i]);
          m_mv = 1; m_lp = per; m_lh = hi;
          np = (per != PER);
          nh = (hi < HMIN) || (hi > HMAX);
          if (np || nh) begin
            m_good = 0; m_locked = 0; m_mode = 2;
          end else if (m_mode == 2) begin
            m_good++;
            if (m_good >= LOCK_N) begin m_mode = 3; m_locked = 1; end
          end
        end else begin
          m_mode = 2;
        end
        m_start = edge_i;
      end else if (n + 2 - m_start >= 2 * PER) begin
        nt = 1; m_locked = 0; m_good = 0; m_mode = 1; m_start = n + 2;
      end
    end
    m_perr = (m_perr & ~c_in) | np;
    m_herr = (m_herr & ~c_in) | nh;
    m_terr = (m_terr & ~c_in) | nt;
  endtask

  task automatic add(input bit v, input int cnt);
    repeat (cnt) wq.push_back(v);
  endtask

  task automatic add_period(input int len, input int hi);
    add(1'b1, hi);
    add(1'b0, len - hi);
  endtask

  task automatic ideal(input int pairs);
    repeat (pairs) begin
      add_period(PER, 5);
      add_period(PER, 4);
    end
  endtask

  // Half-sample a is sampled at the next falling edge, b at the following rising edge.
  task automatic play();
    bit a, b, c;
    while (wq.size() > 0) begin
      a = wq.pop_front();
      if (wq.size() > 0) b = wq.pop_front();
      else b = a;
      c = clr_hold | clr_pulse;
      clr_pulse = 0;
      @(posedge clk_in); #1;
      clk_div = a; en = en_val; clr_err = c;
      @(negedge clk_in); #1;
      clk_div = b;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int kind, len;
    en_val = 0; clr_hold = 0; clr_pulse = 0;
    model_reset();
    fork
      begin : compare_loop
        forever begin
          @(negedge clk_in);
          a_now = clk_div;
          @(posedge clk_in);
          b_now = clk_div; en_s = en; clr_s = clr_err; rst_s = rst_n;
          if (!rst_s) begin
            model_reset(); pend_a = 0; pend_b = 0;
          end else begin
            model_step(pend_a, pend_b, en_s, clr_s);
            pend_a = a_now; pend_b = b_now;
          end
          #1;
          chk("cycle", outvec(), model_vec());
          if (meas_valid) begin
            meas_cnt++;
            dut_highs.push_back(int'(last_high));
            $display("t=%0t meas period=%0d high=%0d locked=%0b perr=%0b herr=%0b terr=%0b",
                     $time, last_period, last_high, locked, period_err, high_err, timeout_err);
          end
          if (locked && !locked_d) lock_rise_meas = meas_cnt;
          locked_d = locked;
          if (clr_s && period_err) perr_under_clr = 1;
        end
      end
    join_none

    repeat (3) @(posedge clk_in);
    #1 rst_n = 1;
    @(posedge clk_in); #2;
    chk("reset_outputs", outvec(), 0);

    // T1: ideal /4.5 wave
    en_val = 1;
    base = meas_cnt;
    add(1'b0, 4);
    ideal(6);
    play();
    chk("t1_meas_count", meas_cnt - base, 11);
    chk("t1_high0", dut_highs[base], 5);
    chk("t1_high1", dut_highs[base + 1], 4);
    chk("t1_high2", dut_highs[base + 2], 5);
    chk("t1_high3", dut_highs[base + 3], 4);
    chk("t1_lock_at", lock_rise_meas - base, 4);
    chk("t1_flags", {locked, period_err, high_err, timeout_err}, 4'b1000);
    chk("t1_period", last_period, 9);

    // T2: stuck low after lock
    add(1'b0, 24);
    play();
    chk("t2_timeout", {locked, timeout_err}, 2'b01);
    chk("t2_period_held", last_period, 9);

    // T3: recover, clear, then one stretched period
    ideal(3);
    play();
    clr_pulse = 1;
    ideal(3);
    play();
    chk("t3_clear_flags", {locked, period_err, high_err, timeout_err}, 4'b1000);
    add_period(10, 5);
    ideal(3);
    play();
    chk("t3_stretch_flags", {locked, period_err, high_err, timeout_err}, 4'b1100);

    // T4: high time too long, then clear
    clr_pulse = 1;
    ideal(2);
    add_period(PER, 6);
    add_period(PER, 4);
    ideal(2);
    play();
    chk("t4_high_err", {period_err, high_err, timeout_err}, 3'b010);
    clr_pulse = 1;
    ideal(1);
    play();
    chk("t4_high_cleared", high_err, 0);

    // T5: clear held across a new period error
    perr_under_clr = 0;
    clr_hold = 1;
    ideal(1);
    add_period(10, 5);
    ideal(1);
    play();
    chk("t5_error_wins", perr_under_clr, 1);
    chk("t5_cleared_by_hold", period_err, 0);
    clr_hold = 0;

    // T6: asynchronous reset while locked
    ideal(3);
    play();
    chk("t6_locked_before", locked, 1);
    #2 rst_n = 0;
    #1 chk("t6_async_reset", outvec(), 0);
    en_val = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1;

    // en toggle: locked drops, first partial period discarded
    en_val = 1;
    ideal(3);
    play();
    en_val = 0;
    ideal(1);
    play();
    chk("en_off_unlocked", {locked, meas_valid}, 2'b00);
    chk("en_off_period_held", last_period, 9);
    base = meas_cnt;
    en_val = 1;
    add_period(PER, 5);
    ideal(4);
    play();
    chk("en_on_lock_at", lock_rise_meas - base, 4);

    // random waveforms
    for (int s = 0; s < 400; s++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: add_period(PER, $urandom_range(4, 5));
        4: begin
          len = $urandom_range(4, 14);
          add_period(len, $urandom_range(1, len - 1));
        end
        5: repeat ($urandom_range(2, 10)) wq.push_back(1'($urandom_range(0, 1)));
        6: add(1'($urandom_range(0, 1)), $urandom_range(10, 40));
        7: begin
          clr_pulse = 1;
          add_period(PER, 5);
        end
        8: begin
          play();
          en_val = 0;
          add_period(PER, 5);
          play();
          en_val = 1;
          add_period(PER, 4);
        end
        default: add_period(PER, $urandom_range(3, 6));
      endcase
      play();
    end
    repeat (4) @(posedge clk_in);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
